// File: rtl/hw_sw_comm_pkg.sv
// Shared types for the CPU-to-fabric message channel: command/status codes,
// channel FSM states and the state-to-status mapping.
package hw_sw_comm_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DONE  = 2'd1,
        REQ   = 2'd2,
        ABORT = 2'd3
    } hw_cmd_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_ACK  = 2'd2,
        S_ERR  = 2'd3
    } sw_stat_t;

    typedef enum logic [2:0] {
        RESET    = 3'd0,
        WAIT     = 3'd1,
        STALL    = 3'd2,
        READ_MSG = 3'd3,
        ACK_MSG  = 3'd4,
        ERR      = 3'd5
    } chan_state_t;

    localparam logic [7:0] ERR_COUNT_MAX = 8'hFF;

    // Status code software sees while the channel sits in a given state.
    function automatic sw_stat_t state_status(input chan_state_t st);
        case (st)
            STALL:    state_status = S_BUSY;
            READ_MSG: state_status = S_ACK;
            ERR:      state_status = S_ERR;
            default:  state_status = S_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/msg_fifo.sv
// Synchronous first-word-fall-through FIFO; push is ignored when full and pop
// when empty, and the head reads as zero while empty.
module msg_fifo
    import hw_sw_comm_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [DATA_W-1:0]          push_data,
    input  logic                       pop,
    output logic [DATA_W-1:0]          pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [CNT_W-1:0]  count_r;
    logic              do_push_s;
    logic              do_pop_s;

    assign full      = (count_r == CNT_W'(DEPTH));
    assign empty     = (count_r == {CNT_W{1'b0}});
    assign count     = count_r;
    assign do_push_s = push & ~full;
    assign do_pop_s  = pop & ~empty;
    assign pop_data  = empty ? {DATA_W{1'b0}} : mem_r[rd_ptr_r];

    // Storage array: written only on an accepted push, contents need no reset.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Pointers and occupancy; power-of-two depth lets the pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/hw_sw_msg_channel.sv
// CPU PIO to fabric message channel: synchronises the software command, runs the
// handshake FSM, queues payloads in a FWFT FIFO and counts protocol errors.
module hw_sw_msg_channel
    import hw_sw_comm_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int DEPTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [1:0]                 to_hw_sig,
    input  logic [DATA_W-1:0]          to_hw_data,
    output logic [1:0]                 to_sw_sig,
    output logic [DATA_W-1:0]          msg_data,
    output logic                       msg_valid,
    input  logic                       msg_ready,
    output logic [$clog2(DEPTH):0]     fifo_count,
    output logic [7:0]                 err_count
);

    logic [1:0]   sync_r [SYNC_STAGES];
    hw_cmd_t      sig_s;
    chan_state_t  state_r;
    chan_state_t  next_state_s;
    logic [1:0]   to_sw_sig_r;
    logic [7:0]   err_count_r;
    logic         err_inc_s;
    logic         push_s;
    logic         pop_s;
    logic         full_s;
    logic         empty_s;

    assign sig_s     = hw_cmd_t'(sync_r[SYNC_STAGES-1]);
    assign msg_valid = ~empty_s;
    assign pop_s     = msg_valid & msg_ready;
    // One push per REQ phase: only on the edge that enters READ_MSG.
    assign push_s    = (next_state_s == READ_MSG) && (state_r != READ_MSG);
    assign to_sw_sig = to_sw_sig_r;
    assign err_count = err_count_r;

    // Command synchroniser chain from the CPU clock domain.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_r[i] <= 2'b00;
            end
        end else begin
            sync_r[0] <= to_hw_sig;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_r[i] <= sync_r[i-1];
            end
        end
    end

    // Handshake next-state decode and protocol-error detection.
    always_comb begin
        next_state_s = state_r;
        err_inc_s    = 1'b0;
        case (state_r)
            RESET: next_state_s = WAIT;
            WAIT: begin
                case (sig_s)
                    REQ:     next_state_s = full_s ? STALL : READ_MSG;
                    DONE: begin
                        next_state_s = ERR;
                        err_inc_s    = 1'b1;
                    end
                    default: next_state_s = WAIT;
                endcase
            end
            STALL: begin
                if ((sig_s == ABORT) || (sig_s == IDLE)) begin
                    next_state_s = WAIT;
                end else if (!full_s) begin
                    next_state_s = READ_MSG;
                end else begin
                    next_state_s = STALL;
                end
            end
            READ_MSG: begin
                case (sig_s)
                    DONE:        next_state_s = ACK_MSG;
                    IDLE, ABORT: next_state_s = WAIT;
                    default:     next_state_s = READ_MSG;
                endcase
            end
            ACK_MSG: begin
                case (sig_s)
                    IDLE, ABORT: next_state_s = WAIT;
                    REQ: begin
                        next_state_s = ERR;
                        err_inc_s    = 1'b1;
                    end
                    default:     next_state_s = ACK_MSG;
                endcase
            end
            ERR: begin
                if (sig_s == IDLE) begin
                    next_state_s = WAIT;
                end else begin
                    next_state_s = ERR;
                end
            end
            default: next_state_s = RESET;
        endcase
    end

    // State, registered status code and saturating error counter.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r     <= RESET;
            to_sw_sig_r <= S_IDLE;
            err_count_r <= 8'h00;
        end else begin
            state_r     <= next_state_s;
            to_sw_sig_r <= state_status(next_state_s);
            if (err_inc_s && (err_count_r != ERR_COUNT_MAX)) begin
                err_count_r <= err_count_r + 8'h01;
            end else begin
                err_count_r <= err_count_r;
            end
        end
    end

    msg_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push_s),
        .push_data (to_hw_data),
        .pop       (pop_s),
        .pop_data  (msg_data),
        .full      (full_s),
        .empty     (empty_s),
        .count     (fifo_count)
    );

endmodule

// File: tb/tb_hw_sw_msg_channel.sv
// Scoreboard bench for hw_sw_msg_channel: stimulus enqueues expected payloads,
// a negedge monitor compares every consumer pop against that queue.
module tb_hw_sw_msg_channel;
    import hw_sw_comm_pkg::*;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 8;
    localparam int SYNC   = 2;

    logic              clk;
    logic              reset;
    logic [1:0]        to_hw_sig;
    logic [DATA_W-1:0] to_hw_data;
    logic [1:0]        to_sw_sig;
    logic [DATA_W-1:0] msg_data;
    logic              msg_valid;
    wire               msg_ready;
    logic [3:0]        fifo_count;
    logic [7:0]        err_count;

    logic rand_mode;
    logic rnd_ready;
    logic ready_ctl;
    assign msg_ready = rand_mode ? rnd_ready : ready_ctl;

    int pass_cnt = 0;
    int total_cnt = 0;
    int err_exp = 0;
    logic [31:0] exp_q [$];

    hw_sw_msg_channel #(
        .DATA_W      (DATA_W),
        .DEPTH       (DEPTH),
        .SYNC_STAGES (SYNC)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .to_hw_sig  (to_hw_sig),
        .to_hw_data (to_hw_data),
        .to_sw_sig  (to_sw_sig),
        .msg_data   (msg_data),
        .msg_valid  (msg_valid),
        .msg_ready  (msg_ready),
        .fifo_count (fifo_count),
        .err_count  (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        rnd_ready = 1'($urandom_range(0, 1));
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Monitor: every accepted pop must match the oldest expected payload.
    always @(negedge clk) begin
        if (reset && msg_valid && msg_ready) begin
            if (exp_q.size() == 0) begin
                total_cnt++;
                $display("FAIL pop_unexpected: got %0h expected no data", msg_data);
            end else begin
                check("pop_data", msg_data, exp_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_sig(input logic [1:0] v, input string nm);
        int n = 0;
        while (to_sw_sig !== v && n < 300) begin
            tick();
            n++;
        end
        check(nm, 32'(to_sw_sig), 32'(v));
    endtask

    task automatic send_msg(input logic [31:0] d, input logic [1:0] fin);
        to_hw_data = d;
        to_hw_sig  = REQ;
        exp_q.push_back(d);
        wait_sig(S_ACK, "hs_ack");
        to_hw_sig = fin;
        wait_sig(S_IDLE, "hs_release");
        to_hw_sig = IDLE;
        repeat (SYNC + 2) tick();
    endtask

    task automatic drain();
        int n = 0;
        rand_mode = 1'b0;
        ready_ctl = 1'b1;
        while (exp_q.size() != 0 && n < 100) begin
            tick();
            n++;
        end
        check("drain_empty", 32'(exp_q.size()), 32'd0);
        check("drain_count", 32'(fifo_count), 32'd0);
        ready_ctl = 1'b0;
    endtask

    initial begin
        int lat;
        rand_mode  = 1'b0;
        ready_ctl  = 1'b0;
        reset      = 1'b0;
        to_hw_sig  = REQ;
        to_hw_data = 32'h0;

        // Reset holds everything at zero even with REQ asserted.
        repeat (3) tick();
        check("rst_to_sw", 32'(to_sw_sig), 32'd0);
        check("rst_valid", 32'(msg_valid), 32'd0);
        check("rst_fifo_cnt", 32'(fifo_count), 32'd0);
        check("rst_err_cnt", 32'(err_count), 32'd0);
        to_hw_sig = IDLE;
        reset = 1'b1;
        repeat (4) tick();

        // Single full handshake with ACK latency measurement.
        to_hw_data = 32'hCAFE_0001;
        to_hw_sig  = REQ;
        exp_q.push_back(32'hCAFE_0001);
        lat = 0;
        while (to_sw_sig !== S_ACK && lat < 20) begin
            tick();
            lat++;
        end
        check("ack_latency", 32'(lat), 32'(SYNC + 1));
        to_hw_sig = DONE;
        wait_sig(S_IDLE, "done_to_ackmsg");
        to_hw_sig = IDLE;
        repeat (SYNC + 2) tick();
        check("hs_msg_data", msg_data, 32'hCAFE_0001);
        check("hs_msg_valid", 32'(msg_valid), 32'd1);
        check("hs_fifo_cnt", 32'(fifo_count), 32'd1);
        drain();

        // Back-pressure: fill, then a ninth request stalls until one pop.
        for (int i = 1; i <= DEPTH; i++) send_msg(32'(i), DONE);
        check("full_cnt", 32'(fifo_count), 32'(DEPTH));
        to_hw_data = 32'd9;
        to_hw_sig  = REQ;
        exp_q.push_back(32'd9);
        wait_sig(S_BUSY, "stall_busy");
        check("stall_cnt", 32'(fifo_count), 32'(DEPTH));
        ready_ctl = 1'b1;
        tick();
        ready_ctl = 1'b0;
        wait_sig(S_ACK, "stall_release_ack");
        check("refill_cnt", 32'(fifo_count), 32'(DEPTH));
        to_hw_sig = DONE;
        wait_sig(S_IDLE, "stall_done");
        to_hw_sig = IDLE;
        repeat (SYNC + 2) tick();

        // Abort while stalled: no push of the aborted payload.
        to_hw_data = 32'hDEAD_BEEF;
        to_hw_sig  = REQ;
        wait_sig(S_BUSY, "abort_busy");
        to_hw_sig = ABORT;
        wait_sig(S_IDLE, "abort_wait");
        check("abort_cnt", 32'(fifo_count), 32'(DEPTH));
        to_hw_sig = IDLE;
        repeat (SYNC + 2) tick();
        check("abort_cnt_after", 32'(fifo_count), 32'(DEPTH));
        drain();

        // Protocol errors: DONE from WAIT, REQ from ACK_MSG, then saturation.
        to_hw_sig = DONE;
        err_exp++;
        wait_sig(S_ERR, "err_from_wait");
        check("err_cnt_1", 32'(err_count), 32'(err_exp));
        to_hw_sig = IDLE;
        wait_sig(S_IDLE, "err_clear");
        repeat (2) tick();
        to_hw_data = $urandom;
        to_hw_sig  = REQ;
        exp_q.push_back(to_hw_data);
        wait_sig(S_ACK, "err2_ack");
        to_hw_sig = DONE;
        wait_sig(S_IDLE, "err2_ackmsg");
        to_hw_sig = REQ;
        err_exp++;
        wait_sig(S_ERR, "err_from_ackmsg");
        check("err_cnt_2", 32'(err_count), 32'(err_exp));
        check("err2_no_extra_push", 32'(fifo_count), 32'(exp_q.size()));
        to_hw_sig = IDLE;
        wait_sig(S_IDLE, "err2_clear");
        repeat (2) tick();
        while (err_exp < 260) begin
            to_hw_sig = DONE;
            err_exp++;
            wait_sig(S_ERR, "err_loop");
            to_hw_sig = IDLE;
            wait_sig(S_IDLE, "err_loop_clear");
            repeat (2) tick();
        end
        check("err_saturate", 32'(err_count), 32'((err_exp > 255) ? 255 : err_exp));
        drain();

        // Randomised traffic with random consumer readiness and occasional aborts.
        rand_mode = 1'b1;
        for (int i = 0; i < 24; i++) begin
            send_msg($urandom, ($urandom_range(0, 3) == 0) ? ABORT : DONE);
        end
        drain();

        // Reset in the middle of a message with three queued.
        for (int i = 0; i < 3; i++) send_msg($urandom, DONE);
        to_hw_data = 32'h1234_5678;
        to_hw_sig  = REQ;
        wait_sig(S_ACK, "mid_ack");
        reset = 1'b0;
        tick();
        exp_q.delete();
        err_exp = 0;
        check("mid_rst_to_sw", 32'(to_sw_sig), 32'd0);
        check("mid_rst_valid", 32'(msg_valid), 32'd0);
        check("mid_rst_data", msg_data, 32'd0);
        check("mid_rst_fifo_cnt", 32'(fifo_count), 32'd0);
        check("mid_rst_err_cnt", 32'(err_count), 32'(err_exp));
        to_hw_sig = IDLE;
        tick();
        reset = 1'b1;
        repeat (SYNC + 2) tick();
        send_msg(32'hA5A5_0F0F, DONE);
        check("post_rst_cnt", 32'(fifo_count), 32'd1);
        drain();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
